qsys_nios2_ddr3_nios2_qsys_0_oci_trace_capture: RTL and testbench
=================================================================

QSYS_NIOS2_DDR3_NIOS2_QSYS_0_OCI_TRACE_CAPTURE -- requirements
Module: qsys_nios2_ddr3_nios2_qsys_0_oci_trace_capture

Interface
REQ-001 SHALL have parameter DCT_W, default 30, width of one debug-capture-trace word.
REQ-002 SHALL have parameter CNT_W, default 4, width of the valid-slot count.
REQ-003 SHALL have parameter DEPTH, default 16, FIFO entries, power of two >= 2.
REQ-004 SHALL have parameter DROP_W, default 8, width of the saturating drop counter.
REQ-005 SHALL use one clock and asynchronous active-low reset: clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have: reset_n  in  1  async active-low reset.
REQ-007 SHALL have: arm  in  1  pulse; starts capture from IDLE.
REQ-008 SHALL have: dct_valid  in  1  dct_buffer/dct_count qualifier.
REQ-009 SHALL have: dct_buffer  in  DCT_W  trace word.
REQ-010 SHALL have: dct_count  in  CNT_W  valid-slot count; 0 means empty frame.
REQ-011 SHALL have: test_ending  in  1  stop capture, drain remaining entries.
REQ-012 SHALL have: test_has_ended  in  1  abort; flush FIFO, finish at once.
REQ-013 SHALL have: rd_ready  in  1  consumer accepts head entry.
REQ-014 SHALL have: rd_valid  out  1  head entry present.
REQ-015 SHALL have: rd_data  out  DCT_W  head trace word.
REQ-016 SHALL have: rd_count  out  CNT_W  head valid-slot count.
REQ-017 SHALL have: fill_level  out  log2(DEPTH)+1  stored entries.
REQ-018 SHALL have: overflow  out  1  sticky; a frame was dropped.
REQ-019 SHALL have: drop_count  out  DROP_W  dropped frames, saturating.
REQ-020 SHALL have: state  out  2  current FSM state.
REQ-021 SHALL have: done  out  1  high while in ENDED.

Function
REQ-022 SHALL implement FSM IDLE(0), CAPTURE(1), DRAIN(2), ENDED(3).
REQ-023 SHALL move IDLE->CAPTURE on arm; arm ignored in every other state.
REQ-024 SHALL move CAPTURE->DRAIN on test_ending; a frame in the same cycle is still pushed.
REQ-025 SHALL move DRAIN->ENDED in the cycle after the FIFO becomes empty, i.e. fill_level==0 and no push.
REQ-026 SHALL move from any state to ENDED on test_has_ended, clearing the FIFO in the same edge; test_has_ended beats test_ending and arm.
REQ-027 SHALL move ENDED->IDLE on arm, clearing overflow and drop_count.
REQ-028 SHALL push {dct_count, dct_buffer} only in CAPTURE with dct_valid=1 and dct_count!=0; frames with count 0 are discarded, not counted.
REQ-029 SHALL accept a push when full only if a pop occurs the same cycle; otherwise the frame is dropped, overflow set, and drop_count incremented, saturating at all-ones.
REQ-030 SHALL be first-word-fall-through: rd_valid = fill_level!=0; a pushed entry is visible on rd_* the cycle after the push edge (latency 1).
REQ-031 SHALL pop on rd_valid && rd_ready in CAPTURE and DRAIN; rd_valid forced 0 in IDLE and ENDED.
REQ-032 SHALL handle simultaneous push and pop with fill_level unchanged; pointers wrap modulo DEPTH.
REQ-033 SHALL hold rd_data/rd_count stable while rd_valid=1 and rd_ready=0.

Reset
REQ-034 SHALL on reset_n=0 asynchronously set state=IDLE, pointers and fill_level=0, overflow=0, drop_count=0, done=0, rd_valid=0.
REQ-035 SHALL discard all stored entries when reset asserts mid-capture; the FIFO memory array is not reset.

Structure
REQ-036 SHALL put state encodings and default parameter values in a shared include/package file, qsys_nios2_ddr3_oci_trace_pkg.
REQ-037 SHALL instantiate one sub-module, qsys_nios2_ddr3_oci_trace_fifo: a parametrised synchronous FWFT FIFO with a flush input. The FSM, drop logic and counters stay in the top level.

Verification
REQ-038 SHALL cover: arm, 3 frames (count 1,2,3), rd_ready=1 -> rd_* show them in order, latency 1, fill_level returns to 0.
REQ-039 SHALL cover: DEPTH=16, rd_ready=0, 18 valid frames -> fill_level=16, overflow=1, drop_count=2; then push+pop when full -> no drop.
REQ-040 SHALL cover: frames with dct_count=0 interleaved -> none stored, drop_count stays 0.
REQ-041 SHALL cover: 5 entries stored, test_ending -> state=DRAIN, further frames ignored; after 5 pops state=ENDED, done=1.
REQ-042 SHALL cover: test_has_ended with 7 entries stored -> next cycle state=ENDED, fill_level=0, rd_valid=0; arm -> IDLE with counters cleared.
REQ-043 SHALL cover: reset_n low mid-CAPTURE, asynchronous to clk -> all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/qsys_nios2_ddr3_oci_trace_pkg.sv
// Shared state encodings and default sizing for the OCI trace capture block.
package qsys_nios2_ddr3_oci_trace_pkg;

  localparam int unsigned DCT_W_DEF  = 30;
  localparam int unsigned CNT_W_DEF  = 4;
  localparam int unsigned DEPTH_DEF  = 16;
  localparam int unsigned DROP_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_ENDED   = 2'd3
  } trace_state_e;

endpackage

// File: rtl/qsys_nios2_ddr3_oci_trace_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; head word is read combinationally.
module qsys_nios2_ddr3_oci_trace_fifo #(
  parameter int unsigned W     = 34,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               wr_data,
  input  logic                       pop,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_fill;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty      = (r_fill == '0);
  assign full       = (r_fill == (AW+1)'(DEPTH));
  assign w_do_pop   = pop && !empty;
  assign w_do_push  = push && (!full || w_do_pop);
  assign rd_data    = r_mem[r_rd_ptr];
  assign fill_level = r_fill;

  // Storage is deliberately left unreset; only pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

endmodule

// File: rtl/qsys_nios2_ddr3_nios2_qsys_0_oci_trace_capture.sv
// Trace capture controller: sequencing FSM, drop accounting and FWFT buffering of trace frames.
//   state    | meaning
//   IDLE     | waiting for arm, buffer empty, no output
//   CAPTURE  | non-empty frames pushed, consumer may pop
//   DRAIN    | no new frames, consumer empties the buffer
//   ENDED    | finished (done=1), counters held until re-arm
module qsys_nios2_ddr3_nios2_qsys_0_oci_trace_capture
  import qsys_nios2_ddr3_oci_trace_pkg::*;
#(
  parameter int unsigned DCT_W  = DCT_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned DROP_W = DROP_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   arm,
  input  logic                   dct_valid,
  input  logic [DCT_W-1:0]       dct_buffer,
  input  logic [CNT_W-1:0]       dct_count,
  input  logic                   test_ending,
  input  logic                   test_has_ended,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [DCT_W-1:0]       rd_data,
  output logic [CNT_W-1:0]       rd_count,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count,
  output logic [1:0]             state,
  output logic                   done
);

  localparam int unsigned EW = CNT_W + DCT_W;

  trace_state_e              r_state;
  logic                      r_overflow;
  logic [DROP_W-1:0]         r_drop_count;

  logic                      w_active;
  logic                      w_frame;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_drop;
  logic                      w_flush;
  logic                      w_full;
  logic                      w_empty;
  logic [EW-1:0]             w_head;
  logic [$clog2(DEPTH):0]    w_fill;

  assign w_active = (r_state == ST_CAPTURE) || (r_state == ST_DRAIN);
  assign w_flush  = test_has_ended;
  assign rd_valid = w_active && !w_empty;
  assign w_pop    = rd_valid && rd_ready;

  // An abort flushes the buffer, so frames arriving with it neither push nor count as drops.
  assign w_frame  = (r_state == ST_CAPTURE) && dct_valid && (dct_count != '0) && !test_has_ended;
  assign w_push   = w_frame && (!w_full || w_pop);
  assign w_drop   = w_frame && w_full && !w_pop;

  qsys_nios2_ddr3_oci_trace_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (w_flush),
    .push       (w_push),
    .wr_data    ({dct_count, dct_buffer}),
    .pop        (w_pop),
    .rd_data    (w_head),
    .fill_level (w_fill),
    .full       (w_full),
    .empty      (w_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (test_has_ended) begin
      r_state <= ST_ENDED;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (arm) r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (test_ending) r_state <= ST_DRAIN;
          if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != '1) r_drop_count <= r_drop_count + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_empty && !w_push) r_state <= ST_ENDED;
        end
        ST_ENDED: begin
          if (arm) begin
            r_state      <= ST_IDLE;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_data    = w_head[DCT_W-1:0];
  assign rd_count   = w_head[DCT_W +: CNT_W];
  assign fill_level = w_fill;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  assign state      = r_state;
  assign done       = (r_state == ST_ENDED);

endmodule

// File: tb/tb_qsys_nios2_ddr3_nios2_qsys_0_oci_trace_capture.sv
// Directed bench for the OCI trace capture block with hand-computed expectations.
module tb_qsys_nios2_ddr3_nios2_qsys_0_oci_trace_capture;

  logic        clk;
  logic        reset_n;
  logic        arm;
  logic        dct_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;
  logic        rd_ready;
  logic        rd_valid;
  logic [29:0] rd_data;
  logic [3:0]  rd_count;
  logic [4:0]  fill_level;
  logic        overflow;
  logic [7:0]  drop_count;
  logic [1:0]  state;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  qsys_nios2_ddr3_nios2_qsys_0_oci_trace_capture dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .arm            (arm),
    .dct_valid      (dct_valid),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .rd_ready       (rd_ready),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .rd_count       (rd_count),
    .fill_level     (fill_level),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .state          (state),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic v, input logic [3:0] c, input logic [29:0] d);
    dct_valid  = v;
    dct_count  = c;
    dct_buffer = d;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_fill"}, 32'(fill_level), 0);
    chk({tag, "_rdv"}, 32'(rd_valid), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_drop"}, 32'(drop_count), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    reset_n = 1'b0; arm = 1'b0; test_ending = 1'b0; test_has_ended = 1'b0;
    rd_ready = 1'b0;
    frame(1'b0, 4'd0, 30'd0);
    #12;
    chk_reset_vals("rst");
    reset_n = 1'b1;

    // three frames, consumer always ready
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("arm_state", 32'(state), 1);
    rd_ready = 1'b1;
    arm = 1'b1;
    frame(1'b1, 4'd1, 30'h0000_1111);
    tick();
    arm = 1'b0;
    chk("f1_state", 32'(state), 1);
    chk("f1_rdv", 32'(rd_valid), 1);
    chk("f1_data", 32'(rd_data), 32'h0000_1111);
    chk("f1_cnt", 32'(rd_count), 1);
    chk("f1_fill", 32'(fill_level), 1);
    frame(1'b1, 4'd2, 30'h0000_2222);
    tick();
    chk("f2_data", 32'(rd_data), 32'h0000_2222);
    chk("f2_cnt", 32'(rd_count), 2);
    chk("f2_fill", 32'(fill_level), 1);
    frame(1'b1, 4'd3, 30'h0000_3333);
    tick();
    chk("f3_data", 32'(rd_data), 32'h0000_3333);
    chk("f3_cnt", 32'(rd_count), 3);
    frame(1'b0, 4'd0, 30'd0);
    tick();
    chk("f_end_fill", 32'(fill_level), 0);
    chk("f_end_rdv", 32'(rd_valid), 0);

    // zero-count frames are discarded
    rd_ready = 1'b0;
    frame(1'b1, 4'd0, 30'h0000_0AAA); tick();
    frame(1'b1, 4'd5, 30'h0000_0555); tick();
    frame(1'b1, 4'd0, 30'h0000_0BBB); tick();
    frame(1'b1, 4'd7, 30'h0000_0777); tick();
    frame(1'b1, 4'd0, 30'h0000_0CCC); tick();
    frame(1'b0, 4'd0, 30'd0);
    chk("z_fill", 32'(fill_level), 2);
    chk("z_drop", 32'(drop_count), 0);
    chk("z_ovf", 32'(overflow), 0);
    chk("z_head", 32'(rd_data), 32'h0000_0555);
    chk("z_head_cnt", 32'(rd_count), 5);
    rd_ready = 1'b1;
    tick();
    chk("z_head2", 32'(rd_data), 32'h0000_0777);
    tick();
    chk("z_empty", 32'(fill_level), 0);

    // overflow: 18 frames into 16 entries
    rd_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      frame(1'b1, 4'((i % 15) + 1), 30'(100 + i));
      tick();
      if (i == 15) begin
        chk("of_full_fill", 32'(fill_level), 16);
        chk("of_full_ovf", 32'(overflow), 0);
      end
    end
    chk("of_fill", 32'(fill_level), 16);
    chk("of_ovf", 32'(overflow), 1);
    chk("of_drop", 32'(drop_count), 2);
    chk("of_head", 32'(rd_data), 100);
    rd_ready = 1'b1;
    frame(1'b1, 4'd9, 30'h2AAA_AAAA);
    tick();
    frame(1'b0, 4'd0, 30'd0);
    chk("pp_fill", 32'(fill_level), 16);
    chk("pp_drop", 32'(drop_count), 2);
    chk("pp_head_cnt", 32'(rd_count), 2);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("of_drain%0d", k), 32'(rd_data), (k < 15) ? 32'(101 + k) : 32'h2AAA_AAAA);
      tick();
    end
    chk("of_drained", 32'(fill_level), 0);
    chk("of_ovf_sticky", 32'(overflow), 1);

    // graceful end: 5 entries, the fifth arriving with test_ending
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      frame(1'b1, 4'd3, 30'(200 + i));
      tick();
    end
    frame(1'b1, 4'd3, 30'd204);
    test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
    chk("dr_state", 32'(state), 2);
    chk("dr_fill", 32'(fill_level), 5);
    frame(1'b1, 4'd4, 30'd999);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("dr_ignore_fill", 32'(fill_level), 5);
    chk("dr_ignore_state", 32'(state), 2);
    rd_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("dr_pop%0d", k), 32'(rd_data), 32'(200 + k));
      tick();
    end
    frame(1'b0, 4'd0, 30'd0);
    chk("dr_empty_fill", 32'(fill_level), 0);
    chk("dr_empty_state", 32'(state), 2);
    tick();
    chk("end_state", 32'(state), 3);
    chk("end_done", 32'(done), 1);
    chk("end_rdv", 32'(rd_valid), 0);
    chk("end_ovf_held", 32'(overflow), 1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("rearm_state", 32'(state), 0);
    chk("rearm_ovf", 32'(overflow), 0);
    chk("rearm_drop", 32'(drop_count), 0);
    chk("rearm_done", 32'(done), 0);

    // drop counter saturation, then abort with a full buffer
    arm = 1'b1;
    tick();
    arm = 1'b0;
    rd_ready = 1'b0;
    for (int i = 0; i < 276; i++) begin
      frame(1'b1, 4'd1, 30'(i));
      tick();
    end
    chk("sat_drop", 32'(drop_count), 255);
    chk("sat_fill", 32'(fill_level), 16);
    test_has_ended = 1'b1;
    tick();
    test_has_ended = 1'b0;
    frame(1'b0, 4'd0, 30'd0);
    chk("sat_abort_state", 32'(state), 3);
    chk("sat_abort_drop", 32'(drop_count), 255);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("sat_clr_drop", 32'(drop_count), 0);
    chk("sat_clr_ovf", 32'(overflow), 0);

    // abort with 7 entries beats test_ending and arm
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 7; i++) begin
      frame(1'b1, 4'd6, 30'(300 + i));
      tick();
    end
    chk("ab_fill7", 32'(fill_level), 7);
    test_has_ended = 1'b1;
    test_ending = 1'b1;
    arm = 1'b1;
    tick();
    test_has_ended = 1'b0;
    test_ending = 1'b0;
    arm = 1'b0;
    frame(1'b0, 4'd0, 30'd0);
    chk("ab_state", 32'(state), 3);
    chk("ab_fill", 32'(fill_level), 0);
    chk("ab_rdv", 32'(rd_valid), 0);
    chk("ab_done", 32'(done), 1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk_reset_vals("ab_idle");

    // asynchronous reset mid-capture
    arm = 1'b1;
    tick();
    arm = 1'b0;
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      frame(1'b1, 4'd2, 30'(400 + i));
      tick();
    end
    frame(1'b0, 4'd0, 30'd0);
    chk("ar_pre_fill", 32'(fill_level), 3);
    #2 reset_n = 1'b0;
    #1;
    chk_reset_vals("ar");
    #2 reset_n = 1'b1;
    tick();
    chk("ar_after_state", 32'(state), 0);
    chk("ar_after_fill", 32'(fill_level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
